ladner_fischer_pipe: RTL

Parametrised, pipelined Ladner-Fischer parallel-prefix adder/subtractor with valid/ready handshake, sideband tag and NZCV-style flags. It is the next-generation datapath adder for the ALU and accumulator paths. It replaces fixed-width combinational prefix adders wherever timing closure needs register cuts inside the prefix tree. Throughput is one operation per cycle, with full backpressure support.

---
 rtl/ladner_fischer_pkg.sv | 29 ++
 rtl/ladner_fischer_pipe_level.sv | 25 ++
 rtl/ladner_fischer_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ladner_fischer_pkg.sv
// Shared helpers for the pipelined Ladner-Fischer adder: tree depth, register cut
// placement, the prefix combine cell and the registered flag bundle.
package ladner_fischer_pkg;

    typedef struct packed {
        logic cout;
        logic v;
        logic z;
        logic n;
    } lf_flags_t;

    function automatic int lf_levels(input int width);
        int l;
        l = 0;
        for (int w = 1; w < width; w = w * 2) l++;
        return l;
    endfunction

    // Prefix level after which stage k is registered; k == num_stages maps to the full tree.
    function automatic int lf_cut_level(input int k, input int num_stages, input int width);
        return (2 * k * lf_levels(width) + num_stages) / (2 * num_stages);
    endfunction

    function automatic logic [1:0] lf_combine(input logic gi, input logic pi,
                                              input logic gj, input logic pj);
        return {gi | (pi & gj), pi & pj};
    endfunction

endpackage

// File: rtl/ladner_fischer_pipe_level.sv
// One combinational Ladner-Fischer prefix level: bits whose LEVEL bit is set absorb
// the group ending just below their 2^(LEVEL+1)-aligned half-block.
module lf_prefix_level
    import ladner_fischer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> LEVEL) & 1) == 1) begin : g_comb
            localparam int J = ((i >> (LEVEL + 1)) << (LEVEL + 1)) + (1 << LEVEL) - 1;
            assign {g_out[i], p_out[i]} = lf_combine(g_in[i], p_in[i], g_in[J], p_in[J]);
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/ladner_fischer_pipe.sv
// Pipelined Ladner-Fischer adder/subtractor with valid/ready flow control, tag
// sideband and NZCV flags; register cuts are spread evenly over the prefix tree.
module ladner_fischer_pipe
    import ladner_fischer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [WIDTH-1:0] g_grp;
        logic [WIDTH-1:0] p_grp;
        logic [WIDTH-1:0] p_bit;
        logic             c_eff;
        logic [TAG_W-1:0] tag;
    } payload_t;

    payload_t seg_in  [NUM_STAGES];
    payload_t seg_out [NUM_STAGES];

    logic [NUM_STAGES:0]   vld;
    logic [NUM_STAGES+1:1] rdy;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c_eff = in_sub ? ~in_cin : in_cin;

    assign seg_in[0] = '{g_grp: in_a & b_eff, p_grp: in_a ^ b_eff, p_bit: in_a ^ b_eff,
                         c_eff: c_eff, tag: in_tag};

    // Stage k is ready when empty or when its successor drains this cycle.
    assign vld[0]              = in_valid;
    assign vld[NUM_STAGES]     = out_valid;
    assign rdy[NUM_STAGES + 1] = out_ready;
    for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_rdy
        assign rdy[k] = !vld[k] | rdy[k + 1];
    end
    assign in_ready = rdy[1];

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_seg
        localparam int LO = lf_cut_level(s, NUM_STAGES, WIDTH);
        localparam int HI = lf_cut_level(s + 1, NUM_STAGES, WIDTH);

        logic [WIDTH-1:0] g_ch [LO:HI];
        logic [WIDTH-1:0] p_ch [LO:HI];

        assign g_ch[LO] = seg_in[s].g_grp;
        assign p_ch[LO] = seg_in[s].p_grp;

        for (genvar lv = LO; lv < HI; lv++) begin : g_lvl
            lf_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (lv)
            ) u_level (
                .g_in  (g_ch[lv]),
                .p_in  (p_ch[lv]),
                .g_out (g_ch[lv + 1]),
                .p_out (p_ch[lv + 1])
            );
        end

        assign seg_out[s] = '{g_grp: g_ch[HI], p_grp: p_ch[HI], p_bit: seg_in[s].p_bit,
                              c_eff: seg_in[s].c_eff, tag: seg_in[s].tag};
    end

    for (genvar s = 1; s < NUM_STAGES; s++) begin : g_stage
        payload_t data_q;
        logic     valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (rdy[s]) begin
                valid_q <= vld[s - 1];
                if (vld[s - 1]) data_q <= seg_out[s - 1];
            end
        end

        assign vld[s]    = valid_q;
        assign seg_in[s] = data_q;
    end

    payload_t         fin;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    lf_flags_t        flags_q;

    assign fin   = seg_out[NUM_STAGES - 1];
    assign carry = fin.g_grp | (fin.p_grp & {WIDTH{fin.c_eff}});
    assign sum   = fin.p_bit ^ {carry[WIDTH-2:0], fin.c_eff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_tag   <= '0;
            flags_q   <= '0;
        end else if (rdy[NUM_STAGES]) begin
            out_valid <= vld[NUM_STAGES - 1];
            if (vld[NUM_STAGES - 1]) begin
                out_s   <= sum;
                out_tag <= fin.tag;
                flags_q <= '{cout: carry[WIDTH-1], v: carry[WIDTH-1] ^ carry[WIDTH-2],
                             z: (sum == '0), n: sum[WIDTH-1]};
            end
        end
    end

    assign out_cout = flags_q.cout;
    assign out_v    = flags_q.v;
    assign out_z    = flags_q.z;
    assign out_n    = flags_q.n;

endmodule
